gf180mcu_sync_debounce: RTL and testbench

GF180MCU_SYNC_DEBOUNCE -- requirements
Module: gf180mcu_sync_debounce

---
 rtl/gf180mcu_sync_debounce_if.sv | 15 +
 rtl/gf180mcu_sync_debounce.sv | 68 ++++++
 tb/tb_gf180mcu_sync_debounce.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_sync_debounce_if.sv
// Signal bundle for the synchronizing debouncer: raw input and enable in,
// filtered level, edge pulses and a counter observation port out.
interface gf180mcu_sync_debounce_if #(
  parameter int CNT_W = 4
);
  logic             I;
  logic             EN;
  logic             Z;
  logic             RISE;
  logic             FALL;
  logic [CNT_W-1:0] DBG_CNT;

  modport master (output I, EN, input Z, RISE, FALL, DBG_CNT);
  modport slave  (input I, EN, output Z, RISE, FALL, DBG_CNT);
endinterface

// File: rtl/gf180mcu_sync_debounce.sv
// Two-flop synchronizer followed by a saturating debounce counter; Z follows
// the synchronized input only after STABLE_CYC consecutive differing samples.
module gf180mcu_sync_debounce #(
  parameter int   STABLE_CYC = 8,
  parameter int   CNT_W      = 4,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  inout  wire                      VDD,
  inout  wire                      VSS,
  gf180mcu_sync_debounce_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);

  logic             s1_q, s2_q;
  logic             z_q, z_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Supply pins carry no logic; this net only keeps them referenced.
  wire unused_supply = VDD ^ VSS;

  // Filter decision works on s2 only, so I and EN never reach an output
  // without passing through a flop.
  always_comb begin
    cnt_d  = cnt_q;
    z_d    = z_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (bus.EN) begin
      if (s2_q == z_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        z_d    = s2_q;
        cnt_d  = '0;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      z_q    <= RST_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= bus.I;
      s2_q   <= s1_q;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.Z       = z_q;
  assign bus.RISE    = rise_q;
  assign bus.FALL    = fall_q;
  assign bus.DBG_CNT = cnt_q;
endmodule

// File: tb/tb_gf180mcu_sync_debounce.sv
// Directed bench for gf180mcu_sync_debounce: five parameter variants share one
// stimulus stream and are checked every cycle against a run-length model.
module tb_gf180mcu_sync_debounce;
  localparam int NI = 5;
  localparam int STABS [NI] = '{8, 8, 1, 2, 15};
  localparam bit RVS   [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_drv = 1'b1;
  logic i_drv   = 1'b0;
  logic en_drv  = 1'b1;

  wire vdd_w;
  wire vss_w;
  assign vdd_w = 1'b1;
  assign vss_w = 1'b0;

  logic [NI-1:0]      z_w, rise_w, fall_w;
  logic [NI-1:0][3:0] dbg_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gf180mcu_sync_debounce_if #(.CNT_W(4)) u_if ();
    assign u_if.I  = i_drv;
    assign u_if.EN = en_drv;
    gf180mcu_sync_debounce #(
      .STABLE_CYC(STABS[g]),
      .CNT_W     (4),
      .RST_VAL   (RVS[g])
    ) u_dut (
      .CLK(clk),
      .RST(rst_drv),
      .VDD(vdd_w),
      .VSS(vss_w),
      .bus(u_if)
    );
    assign z_w[g]    = u_if.Z;
    assign rise_w[g] = u_if.RISE;
    assign fall_w[g] = u_if.FALL;
    assign dbg_w[g]  = u_if.DBG_CNT;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each variant: raw input delayed by two samples; Z flips to the delayed
  // value once it has disagreed with Z for STABLE_CYC consecutive enabled edges.
  int edge_n = 0;
  bit model_on = 1'b0;
  bit m_p1 [NI], m_p2 [NI], m_z [NI], m_rise [NI], m_fall [NI];
  int m_run [NI];

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      if (rst_drv) begin
        m_p1[k] = RVS[k]; m_p2[k] = RVS[k]; m_z[k] = RVS[k];
        m_run[k] = 0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
      end else begin
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (en_drv) begin
          if (m_p2[k] == m_z[k]) m_run[k] = 0;
          else begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == STABS[k]) begin
              m_z[k] = m_p2[k];
              m_run[k] = 0;
              if (m_z[k]) m_rise[k] = 1'b1;
              else        m_fall[k] = 1'b1;
            end
          end
        end
        m_p2[k] = m_p1[k];
        m_p1[k] = i_drv;
      end
    end
    if (rst_drv) model_on = 1'b1;
  end

  // Per-variant pulse bookkeeping used by the directed literal checks.
  int rise_cnt [NI], fall_cnt [NI], last_rise [NI], last_fall [NI];
  initial for (int k = 0; k < NI; k++) begin
    rise_cnt[k] = 0; fall_cnt[k] = 0; last_rise[k] = -1; last_fall[k] = -1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("z[%0d]", k),    int'(z_w[k]),    int'(m_z[k]));
        chk($sformatf("rise[%0d]", k), int'(rise_w[k]), int'(m_rise[k]));
        chk($sformatf("fall[%0d]", k), int'(fall_w[k]), int'(m_fall[k]));
        chk($sformatf("cnt[%0d]", k),  int'(dbg_w[k]),  m_run[k]);
        chk($sformatf("excl[%0d]", k), int'(rise_w[k] & fall_w[k]), 0);
        if (rise_w[k]) begin rise_cnt[k]++; last_rise[k] = edge_n; end
        if (fall_w[k]) begin fall_cnt[k]++; last_fall[k] = edge_n; end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  int start, rc, fc;
  int lat_exp [NI] = '{9, -1, 2, 3, 16};

  initial begin
    // reset state
    step(2);
    chk("rst_z_a", int'(z_w[0]), 0);
    chk("rst_z_b", int'(z_w[1]), 1);
    chk("rst_cnt_a", int'(dbg_w[0]), 0);
    chk("rst_rise_a", int'(rise_w[0]), 0);

    // clean rise
    rst_drv = 1'b0; i_drv = 1'b1; start = edge_n + 1;
    step(9);
    chk("rise_pre_z", int'(z_w[0]), 0);
    step(1);
    chk("rise_z", int'(z_w[0]), 1);
    chk("rise_pulse", int'(rise_w[0]), 1);
    step(1);
    chk("rise_after", int'(rise_w[0]), 0);
    step(10);
    for (int k = 0; k < NI; k++)
      if (lat_exp[k] >= 0) chk($sformatf("rise_lat[%0d]", k), last_rise[k] - start, lat_exp[k]);
    chk("b_no_rise", rise_cnt[1], 0);

    // glitch low while Z=1
    fc = fall_cnt[0];
    i_drv = 1'b0; step(5);
    i_drv = 1'b1; step(12);
    chk("glitch_lo_z", int'(z_w[0]), 1);
    chk("glitch_lo_nofall", fall_cnt[0] - fc, 0);

    // fall
    fc = fall_cnt[0];
    i_drv = 1'b0; start = edge_n + 1;
    step(20);
    chk("fall_z", int'(z_w[0]), 0);
    chk("fall_once", fall_cnt[0] - fc, 1);
    chk("fall_lat_a", last_fall[0] - start, 9);
    chk("fall_lat_c", last_fall[2] - start, 2);
    chk("fall_lat_e", last_fall[4] - start, 16);

    // glitch high while Z=0
    rc = rise_cnt[0];
    i_drv = 1'b1; step(5);
    i_drv = 1'b0; step(12);
    chk("glitch_hi_z", int'(z_w[0]), 0);
    chk("glitch_hi_norise", rise_cnt[0] - rc, 0);

    // freeze with cnt=3
    i_drv = 1'b1; step(5);
    chk("frz_cnt_pre", int'(dbg_w[0]), 3);
    en_drv = 1'b0; step(4);
    chk("frz_cnt_hold", int'(dbg_w[0]), 3);
    chk("frz_z_hold", int'(z_w[0]), 0);
    en_drv = 1'b1; step(4);
    chk("frz_cnt_resume", int'(dbg_w[0]), 7);
    chk("frz_z_resume", int'(z_w[0]), 0);
    step(1);
    chk("frz_z_rise", int'(z_w[0]), 1);
    chk("frz_rise", int'(rise_w[0]), 1);
    step(16);

    // reset mid-count
    i_drv = 1'b0; step(8);
    chk("mid_cnt", int'(dbg_w[0]), 6);
    fc = fall_cnt[0];
    rst_drv = 1'b1; step(1);
    chk("mid_rst_z_a", int'(z_w[0]), 0);
    chk("mid_rst_cnt", int'(dbg_w[0]), 0);
    chk("mid_rst_z_b", int'(z_w[1]), 1);
    rst_drv = 1'b0; step(13);
    chk("mid_no_fall", fall_cnt[0] - fc, 0);

    // reset coinciding with the threshold edge
    rc = rise_cnt[0];
    i_drv = 1'b1; step(9);
    chk("thr_cnt", int'(dbg_w[0]), 7);
    rst_drv = 1'b1; step(1);
    chk("thr_z", int'(z_w[0]), 0);
    chk("thr_cnt_clr", int'(dbg_w[0]), 0);
    rst_drv = 1'b0; i_drv = 1'b0; step(3);
    chk("thr_no_rise", rise_cnt[0] - rc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
